// File: rtl/afb_frame_player.sv
// Frame buffer replay source for the AFB input: plays a stored I/Q frame a programmed
// number of times with start offset, idle gap and valid/ready backpressure.
module afb_frame_player #(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 1024,
  parameter int ITER_W = 16,
  parameter int GAP_W  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_inph,
  input  logic [WIDTH-1:0]  wr_quad,
  input  logic [AW:0]       cfg_len,
  input  logic [AW-1:0]     cfg_start_idx,
  input  logic [ITER_W-1:0] cfg_iters,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              start,
  input  logic              abort,
  output logic [WIDTH-1:0]  out_inph,
  output logic [WIDTH-1:0]  out_quad,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRESENT, S_GAP, S_DONE} state_t;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] rd_data;
  logic [AW-1:0]      rd_addr;

  // Registered read: a same-cycle write to the read address returns the old word.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= {wr_inph, wr_quad};
    rd_data <= mem[rd_addr];
  end

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d, pos_q, pos_d;
  logic [AW:0]       len_q, len_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [GAP_W-1:0]  gap_q, gap_d, gcnt_q, gcnt_d;
  logic              fetched_q, fetched_d;
  logic [WIDTH-1:0]  out_inph_q, out_inph_d, out_quad_q, out_quad_d;
  logic              out_valid_q, out_valid_d, sof_q, sof_d, eof_q, eof_d;
  logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] i, input logic [AW:0] l);
    return (({1'b0, i} + (AW+1)'(1)) == l) ? '0 : i + AW'(1);
  endfunction

  logic          hs, len_ok, pos_last, posn_last;
  logic [AW-1:0] idx_n1, idx_n2, pos_n, start_eff;

  always_comb begin
    hs        = out_valid_q & out_ready;
    idx_n1    = wrap_inc(idx_q, len_q);
    idx_n2    = wrap_inc(idx_n1, len_q);
    pos_n     = wrap_inc(pos_q, len_q);
    pos_last  = (({1'b0, pos_q} + (AW+1)'(1)) == len_q);
    posn_last = (({1'b0, pos_n} + (AW+1)'(1)) == len_q);
    len_ok    = (cfg_len != '0) && (cfg_len <= (AW+1)'(DEPTH));
    start_eff = ({1'b0, cfg_start_idx} >= cfg_len) ? '0 : cfg_start_idx;

    state_d     = state_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    len_d       = len_q;
    iter_d      = iter_q;
    gap_d       = gap_q;
    gcnt_d      = gcnt_q;
    fetched_d   = fetched_q;
    out_inph_d  = out_inph_q;
    out_quad_d  = out_quad_q;
    out_valid_d = out_valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    rd_addr     = idx_q;

    // rd_data always holds the word the next load needs, so gap=0 streams without bubbles.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d     = cfg_len;
            iter_d    = cfg_iters;
            gap_d     = cfg_gap;
            idx_d     = start_eff;
            pos_d     = '0;
            fetched_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_FETCH;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (!fetched_q) begin
          fetched_d = 1'b1;
        end else begin
          rd_addr     = idx_n1;
          {out_inph_d, out_quad_d} = rd_data;
          sof_d       = (pos_q == '0);
          eof_d       = pos_last;
          out_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end
      end
      S_PRESENT: begin
        rd_addr = idx_n1;
        if (hs) begin
          idx_d = idx_n1;
          pos_d = pos_n;
          if (pos_last && iter_q != '0) iter_d = iter_q - ITER_W'(1);
          if (pos_last && iter_q == ITER_W'(1)) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_DONE;
          end else if (gap_q == '0) begin
            rd_addr  = idx_n2;
            {out_inph_d, out_quad_d} = rd_data;
            sof_d    = (pos_n == '0);
            eof_d    = posn_last;
          end else begin
            out_valid_d = 1'b0;
            gcnt_d      = gap_q;
            state_d     = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_W'(1)) begin
          rd_addr     = idx_n1;
          {out_inph_d, out_quad_d} = rd_data;
          sof_d       = (pos_q == '0);
          eof_d       = pos_last;
          out_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pos_q       <= '0;
      len_q       <= '0;
      iter_q      <= '0;
      gap_q       <= '0;
      gcnt_q      <= '0;
      fetched_q   <= 1'b0;
      out_inph_q  <= '0;
      out_quad_q  <= '0;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      len_q       <= len_d;
      iter_q      <= iter_d;
      gap_q       <= gap_d;
      gcnt_q      <= gcnt_d;
      fetched_q   <= fetched_d;
      out_inph_q  <= out_inph_d;
      out_quad_q  <= out_quad_d;
      out_valid_q <= out_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_inph  = out_inph_q;
  assign out_quad  = out_quad_q;
  assign out_valid = out_valid_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
